dram_line_reader: RTL and testbench
===================================

Name: dram_line_reader

Overview:
- AXI4 read master that services line-fetch requests from the HDMI address generator.
- Takes one kick/read_addr/read_num request and splits it into AXI bursts, each limited by MAX_BURST and by the 4 KB boundary.
- Streams the returned 32-bit words onto buf_dout/buf_we, which feed the pixel FIFO write side.
- Runs in the DRAM/AXI clock domain; busy is synchronised by the consumer.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- MAX_BURST, 16, maximum beats per burst; legal range 1..256.
- ID_WIDTH, 1, AXI ID width; arid is driven constant 0.

Ports:
- clk  in  1  AXI/DRAM clock
- rst  in  1  asynchronous, active-high reset
- kick  in  1  request strobe; sampled only while busy=0
- read_addr  in  32  byte start address; bits [1:0] ignored (forced 0)
- read_num  in  32  number of 32-bit words to fetch
- busy  out  1  request in progress
- buf_dout  out  32  read data word
- buf_we  out  1  buf_dout valid, one word per cycle
- m_axi_arid  out  ID_WIDTH  constant 0
- m_axi_araddr  out  ADDR_WIDTH  burst address
- m_axi_arlen  out  8  beats-1
- m_axi_arsize  out  3  constant 3'b010
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rdata  in  32  R data
- m_axi_rresp  in  2  R response
- m_axi_rlast  in  1  last beat
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready

Behaviour:
- Reset values (async, immediate): busy=0, buf_we=0, buf_dout=0, arvalid=0, araddr=0, arlen=0, rready=0, FSM=IDLE, internal counters=0.
- FSM states: IDLE, ADDR, DATA, FLUSH.
- IDLE:
  - kick=1 at cycle N: latch cur_addr={read_addr[31:2],2'b00} and remain=read_num.
  - busy=1 from N+1.
  - remain≠0 → ADDR; remain=0 → FLUSH.
  - kick while busy=1 is ignored and not queued.
- ADDR:
  - beats = min(remain, MAX_BURST, (4096 - cur_addr[11:0])>>2); value lies in 1..MAX_BURST.
  - arvalid=1, araddr=cur_addr, arlen=beats-1 — computed and registered on entry.
  - araddr/arlen held stable while arvalid=1 and arready=0.
  - On arvalid&&arready → DATA; cur_addr += beats*4; remain -= beats; arvalid=0 next cycle.
- DATA:
  - rready=1 throughout; no backpressure, since the downstream FIFO is sized for a line.
  - Each rvalid&&rready at cycle M: buf_dout=rdata and buf_we=1 at M+1 (registered, 1-cycle latency).
  - Beat with rlast=1: remain≠0 → ADDR (next AR issued at M+1); remain=0 → FLUSH.
  - Only one burst outstanding at a time.
- FLUSH: one cycle, lets the final buf_we complete. busy=0 next cycle, then → IDLE.
  - Final R beat at M → final buf_we at M+1 → busy=0 at M+2.
  - read_num=0: busy high exactly 2 cycles, no AR, no buf_we.
- Arithmetic:
  - remain is 32 bits, unsigned; never underflows because beats ≤ remain.
  - cur_addr wraps modulo 2^ADDR_WIDTH.
- Error handling: rresp≠OKAY data is still forwarded unchanged; the transfer is never aborted.
- Reset mid-operation: all state clears immediately and any outstanding AXI burst is abandoned. The integration must reset the interconnect together with this block.

Optional Feature:
- Macro: DRAM_LINE_READER_ERR_CNT_EN.
- Enabled:
  - Adds output err_cnt [15:0], reset 0.
  - Increments on each R handshake with rresp[1]=1; saturates at 16'hFFFF.
  - Adds output len_err [0:0], a sticky flag set when rlast arrives before arlen+1 beats, or when beat arlen+1 lacks rlast.
  - len_err clears only on rst.
- Disabled: neither port exists and no checking logic is built. Burst end is taken from rlast alone.

Test Plan:
- read_addr=0x0, read_num=256, MAX_BURST=16, arready/rvalid always 1 → 16 ARs, arlen=15, araddr 0x000..0x3C0 step 0x40; 256 buf_we carrying rdata in order; busy low 2 cycles after last R beat.
- read_addr=0xFF8, read_num=4 → AR1 araddr=0xFF8 arlen=1; AR2 araddr=0x1000 arlen=1; 4 buf_we.
- read_num=0 → no arvalid, no buf_we, busy=1 for exactly 2 cycles.
- arready held 0 for 10 cycles after arvalid → araddr/arlen unchanged for all 10 cycles; a second kick during busy produces no extra AR; total AR count matches a single request.
- rst asserted mid-burst (beat 5 of 16) → busy, arvalid, buf_we go 0 immediately; a new kick after rst releases starts a clean transfer from the new read_addr.
- With DRAM_LINE_READER_ERR_CNT_EN: 3 beats with rresp=2'b10 → err_cnt=3, data still forwarded; rlast on beat 3 of arlen=3 → len_err=1.

Source files
------------

// File: rtl/dram_line_reader.sv
// AXI4 read master: splits one line request into 4 KB-safe INCR bursts and streams the words to the pixel FIFO.
// Optional DRAM_LINE_READER_ERR_CNT_EN adds rresp error counting (err_cnt) and burst length checking (len_err).
//
// state | meaning
// IDLE  | waiting for kick
// ADDR  | AR request valid, waiting for arready
// DATA  | receiving R beats of the single outstanding burst
// FLUSH | final buf_we drains; busy drops on exit
module dram_line_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kick,
  input  logic [31:0]           read_addr,
  input  logic [31:0]           read_num,
  output logic                  busy,
  output logic [31:0]           buf_dout,
  output logic                  buf_we,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
`ifdef DRAM_LINE_READER_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt,
  output logic                  len_err
`endif
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           remain;
  logic                  flush_cnt;
  logic                  ar_hs, r_hs, ar_issue;
  logic [ADDR_WIDTH-1:0] start_addr, calc_addr;
  logic [31:0]           calc_remain;
  logic [12:0]           page_span;
  logic [12:0]           page_words;
  logic [31:0]           beats;
  logic [8:0]            burst_beats;
  logic [10:0]           burst_bytes;

  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = (state == DATA);

  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid & m_axi_rready;

  assign start_addr  = read_addr[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(3);
  assign calc_addr   = (state == IDLE) ? start_addr : cur_addr;
  assign calc_remain = (state == IDLE) ? read_num : remain;

  // Words left before the next 4 KB page; addresses are word aligned so this is 1..1024.
  assign page_span  = 13'h1000 - {1'b0, calc_addr[11:0]};
  assign page_words = page_span >> 2;

  always_comb begin
    beats = 32'(MAX_BURST);
    if (calc_remain < beats) beats = calc_remain;
    if (32'(page_words) < beats) beats = 32'(page_words);
  end

  assign burst_beats = {1'b0, m_axi_arlen} + 9'd1;
  assign burst_bytes = {burst_beats, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ar_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (kick) begin
          if (read_num != 32'd0) begin
            state_nxt = ADDR;
            ar_issue  = 1'b1;
          end else begin
            state_nxt = FLUSH;
          end
        end
      end
      ADDR: begin
        if (ar_hs) state_nxt = DATA;
      end
      DATA: begin
        if (r_hs && m_axi_rlast) begin
          if (remain != 32'd0) begin
            state_nxt = ADDR;
            ar_issue  = 1'b1;
          end else begin
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == 1'b0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= 1'b0;
      buf_we        <= 1'b0;
      buf_dout      <= 32'd0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= 8'd0;
      cur_addr      <= '0;
      remain        <= 32'd0;
      flush_cnt     <= 1'b0;
    end else begin
      buf_we <= r_hs;
      if (r_hs) buf_dout <= m_axi_rdata;

      if (state == IDLE && kick) begin
        busy     <= 1'b1;
        cur_addr <= start_addr;
        remain   <= read_num;
        // Empty requests hold busy for two cycles so the consumer's synchroniser still sees it.
        flush_cnt <= (read_num == 32'd0);
      end

      if (ar_issue) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= calc_addr;
        m_axi_arlen   <= 8'(beats - 32'd1);
      end else if (ar_hs) begin
        m_axi_arvalid <= 1'b0;
        cur_addr      <= cur_addr + ADDR_WIDTH'(burst_bytes);
        remain        <= remain - 32'(burst_beats);
      end

      if (state == FLUSH) begin
        if (flush_cnt == 1'b0) busy <= 1'b0;
        else                   flush_cnt <= 1'b0;
      end
    end
  end

`ifdef DRAM_LINE_READER_ERR_CNT_EN
  logic [7:0] beat_left;
  logic       unused_resp;

  assign unused_resp = m_axi_rresp[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= 16'd0;
      len_err   <= 1'b0;
      beat_left <= 8'd0;
    end else begin
      if (ar_hs) beat_left <= m_axi_arlen;
      else if (r_hs && beat_left != 8'd0) beat_left <= beat_left - 8'd1;

      if (r_hs && m_axi_rresp[1] && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;

      // rlast must coincide exactly with the final counted beat.
      if (r_hs && (m_axi_rlast != (beat_left == 8'd0))) len_err <= 1'b1;
    end
  end
`else
  logic unused_resp;

  assign unused_resp = &{1'b0, m_axi_rresp};
`endif

endmodule

// File: tb/tb_dram_line_reader.sv
// Directed bench for dram_line_reader: table of line requests against a negedge-driven AXI read slave model.
// Define DRAM_LINE_READER_ERR_CNT_EN to also exercise err_cnt/len_err.
module tb_dram_line_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        kick;
  logic [31:0] read_addr;
  logic [31:0] read_num;
  logic        busy;
  logic [31:0] buf_dout;
  logic        buf_we;
  logic [0:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
`ifdef DRAM_LINE_READER_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic        len_err;
`endif

  dram_line_reader #(.ADDR_WIDTH(32), .MAX_BURST(16), .ID_WIDTH(1)) dut (
    .clk(clk), .rst(rst), .kick(kick), .read_addr(read_addr), .read_num(read_num),
    .busy(busy), .buf_dout(buf_dout), .buf_we(buf_we),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef DRAM_LINE_READER_ERR_CNT_EN
    , .err_cnt(err_cnt), .len_err(len_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] num;
    int          stall;
    bit          bkick;
    int          exp_ar;
    logic [31:0] f_addr;
    logic [7:0]  f_len;
    logic [31:0] l_addr;
    logic [7:0]  l_len;
    int          exp_words;
    int          exp_busy;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // slave / monitor state
  int          ncyc, busy_cnt, fall_cyc, last_r_ncyc, words, ar_cnt, beats_sent;
  bit          seen_busy, burst_active, first_seen;
  logic [31:0] exp_addr, b_addr, first_addr, last_addr, st_exp_addr;
  logic [7:0]  first_len, last_len, st_exp_len;
  int          b_len, beat, stall_left, err_beats, early_idx;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    ncyc++;
    if (busy) begin
      busy_cnt++;
      seen_busy = 1'b1;
    end else if (seen_busy && fall_cyc < 0) begin
      fall_cyc = ncyc;
    end
    if (buf_we) begin
      check("buf_dout", buf_dout, pat(exp_addr));
      exp_addr += 32'd4;
      words++;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
    if (burst_active && m_axi_rready) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = pat(b_addr + 32'(beat) * 32'd4);
      if (err_beats > 0) begin
        m_axi_rresp = 2'b10;
        err_beats--;
      end
      m_axi_rlast = (beat == b_len) || (beat == early_idx);
      if (m_axi_rlast) begin
        burst_active = 1'b0;
        last_r_ncyc  = ncyc;
      end
      beat++;
      beats_sent++;
    end
    if (m_axi_arvalid && stall_left > 0) begin
      m_axi_arready = 1'b0;
      check("araddr_hold", m_axi_araddr, st_exp_addr);
      check("arlen_hold", {24'd0, m_axi_arlen}, {24'd0, st_exp_len});
      stall_left--;
    end else begin
      m_axi_arready = (stall_left == 0);
      if (m_axi_arvalid) begin
        ar_cnt++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_addr = m_axi_araddr;
          first_len  = m_axi_arlen;
        end
        last_addr    = m_axi_araddr;
        last_len     = m_axi_arlen;
        burst_active = 1'b1;
        b_addr       = m_axi_araddr;
        b_len        = int'(m_axi_arlen);
        beat         = 0;
      end
    end
  endtask

  task automatic run_req(input string tag, input vec_t v);
    bit done;
    ncyc = 0; busy_cnt = 0; fall_cyc = -1; last_r_ncyc = -1; words = 0; ar_cnt = 0;
    seen_busy = 1'b0; first_seen = 1'b0; done = 1'b0;
    stall_left  = v.stall;
    st_exp_addr = v.f_addr;
    st_exp_len  = v.f_len;
    exp_addr    = v.addr & ~32'd3;
    cycle();
    kick = 1'b1; read_addr = v.addr; read_num = v.num;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (i == 0) kick = 1'b0;
      if (v.bkick && i == 3) begin
        kick = 1'b1; read_addr = 32'h5000; read_num = 32'd8;
      end
      if (v.bkick && i == 4) kick = 1'b0;
      if (seen_busy && !busy) begin
        done = 1'b1;
        break;
      end
    end
    kick = 1'b0;
    repeat (3) cycle();
    check({tag, " completed"}, {31'd0, done}, 32'd1);
    check({tag, " ar_count"}, 32'(ar_cnt), 32'(v.exp_ar));
    check({tag, " word_count"}, 32'(words), 32'(v.exp_words));
    if (v.exp_ar > 0) begin
      check({tag, " first_araddr"}, first_addr, v.f_addr);
      check({tag, " first_arlen"}, {24'd0, first_len}, {24'd0, v.f_len});
      check({tag, " last_araddr"}, last_addr, v.l_addr);
      check({tag, " last_arlen"}, {24'd0, last_len}, {24'd0, v.l_len});
    end
    if (v.exp_words > 0) check({tag, " busy_fall"}, 32'(fall_cyc), 32'(last_r_ncyc + 2));
    if (v.exp_busy > 0) check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
  endtask

  vec_t vecs[9];
  vec_t v_post;

  initial begin
    vecs[0] = '{32'h0000_0000, 32'd256, 0,  1'b0, 16, 32'h000, 8'd15, 32'h3C0, 8'd15, 256, -1};
    vecs[1] = '{32'h0000_0FF8, 32'd4,   0,  1'b0, 2,  32'hFF8, 8'd1,  32'h1000, 8'd1, 4,   -1};
    vecs[2] = '{32'h0000_0000, 32'd0,   0,  1'b0, 0,  32'h0,   8'd0,  32'h0,   8'd0,  0,    2};
    vecs[3] = '{32'h0000_0100, 32'd20,  10, 1'b1, 2,  32'h100, 8'd15, 32'h140, 8'd3,  20,  -1};
    vecs[4] = '{32'h0000_1003, 32'd5,   0,  1'b0, 1,  32'h1000, 8'd4, 32'h1000, 8'd4, 5,   -1};
    vecs[5] = '{32'h0000_0FC0, 32'd40,  0,  1'b0, 3,  32'hFC0, 8'd15, 32'h1040, 8'd7, 40,  -1};
    vecs[6] = '{32'h0000_0FFC, 32'd1,   0,  1'b0, 1,  32'hFFC, 8'd0,  32'hFFC, 8'd0,  1,   -1};
    vecs[7] = '{32'h0000_0010, 32'd17,  0,  1'b0, 2,  32'h010, 8'd15, 32'h050, 8'd0,  17,  -1};
    vecs[8] = '{32'hFFFF_FFF8, 32'd4,   0,  1'b0, 2,  32'hFFFF_FFF8, 8'd1, 32'h0, 8'd1, 4, -1};
    v_post  = '{32'h0000_2000, 32'd4,   0,  1'b0, 1,  32'h2000, 8'd3, 32'h2000, 8'd3, 4,   -1};

    rst = 1'b1; kick = 1'b0; read_addr = 32'd0; read_num = 32'd0;
    m_axi_arready = 1'b1; m_axi_rdata = 32'd0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    burst_active = 1'b0; err_beats = 0; early_idx = -1; stall_left = 0; beats_sent = 0;
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst buf_we", {31'd0, buf_we}, 32'd0);
    check("rst buf_dout", buf_dout, 32'd0);
    check("rst arvalid", {31'd0, m_axi_arvalid}, 32'd0);
    check("rst araddr", m_axi_araddr, 32'd0);
    check("rst arlen", {24'd0, m_axi_arlen}, 32'd0);
    check("rst rready", {31'd0, m_axi_rready}, 32'd0);
    check("arsize", {29'd0, m_axi_arsize}, 32'd2);
    check("arburst", {30'd0, m_axi_arburst}, 32'd1);
    check("arid", {31'd0, m_axi_arid}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_req($sformatf("v%0d", i), vecs[i]);

    // Reset in the middle of a 16-beat burst, then a clean request.
    beats_sent = 0; exp_addr = 32'd0; stall_left = 0;
    cycle();
    kick = 1'b1; read_addr = 32'h0; read_num = 32'd16;
    cycle();
    kick = 1'b0;
    for (int i = 0; i < 200 && beats_sent < 5; i++) cycle();
    check("rst_mid reached beat 5", {31'd0, beats_sent >= 5}, 32'd1);
    cycle();
    check("rst_mid buf_we before rst", {31'd0, buf_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid busy", {31'd0, busy}, 32'd0);
    check("rst_mid arvalid", {31'd0, m_axi_arvalid}, 32'd0);
    check("rst_mid buf_we", {31'd0, buf_we}, 32'd0);
    check("rst_mid rready", {31'd0, m_axi_rready}, 32'd0);
    burst_active = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_req("post_rst", v_post);

`ifdef DRAM_LINE_READER_ERR_CNT_EN
    err_beats = 3;
    run_req("err_resp", '{32'h3000, 32'd4, 0, 1'b0, 1, 32'h3000, 8'd3, 32'h3000, 8'd3, 4, -1});
    check("err_cnt", {16'd0, err_cnt}, 32'd3);
    check("len_err clean", {31'd0, len_err}, 32'd0);
    early_idx = 2;
    run_req("early_last", '{32'h4000, 32'd4, 0, 1'b0, 1, 32'h4000, 8'd3, 32'h4000, 8'd3, 3, -1});
    early_idx = -1;
    check("len_err set", {31'd0, len_err}, 32'd1);
    check("err_cnt hold", {16'd0, err_cnt}, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
